// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
//
// Multiplexed seven-segment scan driver for NUM_DIGITS digits.
// - A refresh prescaler sets how long each digit slot lasts.
// - Load uses a double buffer. A load strobe captures the codes into a
//   staging buffer. The staging buffer moves to the active buffer only when
//   the scan wraps to digit 0, so a frame is never shown torn.
// - Brightness comes from a free-running PWM counter that gates the
//   digit select.
// - The enable input freezes the scan and blanks the display.
//
// Optional feature (compile-time macro SSD_SCAN_BLINK_EN):
//   Adds parameter BLINK_FRAMES and input blink_mask. Masked digits blink
//   with a phase bit that toggles every BLINK_FRAMES frames.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   displayValues  packed digit codes; the MSB slice is digit 0 (leftmost)
//   load           one-cycle strobe that captures displayValues into staging
//   enable         1 = scan; 0 = prescaler frozen and all digits dark
//   brightness     PWM duty; 0 = dark, all-ones = full on
//   blink_mask     (SSD_SCAN_BLINK_EN only) per-digit blink enable; bit i = digit i
//   pending        staging holds a value that has not been committed yet
//   frame_tick     one-cycle pulse when the scan wraps to digit 0
//   ssdAnode       registered active-low segment pattern {g,f,e,d,c,b,a}
//   ssdCathode     registered active-low digit select; digit 0 is the MSB
// ---------------------------------------------------------------------------
module ssd_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int CODE_W      = 8,
  parameter int REFRESH_DIV = 125_000,
  parameter int BRIGHT_W    = 4
`ifdef SSD_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_DIGITS*CODE_W-1:0] displayValues,
  input  logic                         load,
  input  logic                         enable,
  input  logic [BRIGHT_W-1:0]          brightness,
`ifdef SSD_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]        blink_mask,
`endif
  output logic                         pending,
  output logic                         frame_tick,
  output logic [6:0]                   ssdAnode,
  output logic [NUM_DIGITS-1:0]        ssdCathode
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BUF_W = NUM_DIGITS * CODE_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Hex decode of the low nibble into an active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] seg_decode(input logic [CODE_W-1:0] code);
    logic [6:0] seg;
    case (code[3:0])
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]      count_r;
  logic [IDX_W-1:0]      index_r;
  logic [BRIGHT_W-1:0]   pwm_r;
  logic [BUF_W-1:0]      staging_r;
  logic [BUF_W-1:0]      active_r;
  logic                  pending_r;
  logic                  frame_tick_r;
  logic [6:0]            anode_r;
  logic [NUM_DIGITS-1:0] cathode_r;

  logic                  tick_s;
  logic                  wrap_s;
  logic                  lit_s;
  logic                  blank_s;
  logic [CODE_W-1:0]     code_s;
  logic [NUM_DIGITS-1:0] sel_s;

`ifdef SSD_SCAN_BLINK_EN
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [BLK_W-1:0] blink_cnt_r;
  logic             blink_phase_r;
`endif

  // Slot tick, frame wrap, PWM gate, code of the current digit and its select.
  always_comb begin
    tick_s  = enable && (count_r == CNT_LAST);
    // Committing on the tick that leaves the last digit is the frame boundary.
    wrap_s  = tick_s && (index_r == IDX_LAST);
    lit_s   = (pwm_r < brightness) || (&brightness);
    code_s  = {CODE_W{1'b0}};
    sel_s   = {NUM_DIGITS{1'b1}};
    blank_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      // Digit i sits in slice NUM_DIGITS-1-i and drives cathode bit NUM_DIGITS-1-i.
      code_s = (index_r == IDX_W'(i)) ? active_r[(NUM_DIGITS-1-i)*CODE_W +: CODE_W] : code_s;
      sel_s[NUM_DIGITS-1-i] = (index_r == IDX_W'(i)) ? 1'b0 : 1'b1;
`ifdef SSD_SCAN_BLINK_EN
      blank_s = (index_r == IDX_W'(i)) ? (!blink_phase_r && blink_mask[i]) : blank_s;
`endif
    end
  end

  // Refresh prescaler and digit index; both hold while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CNT_W{1'b0}};
      index_r <= {IDX_W{1'b0}};
    end else if (tick_s) begin
      count_r <= {CNT_W{1'b0}};
      index_r <= (index_r == IDX_LAST) ? {IDX_W{1'b0}} : index_r + IDX_W'(1);
    end else if (enable) begin
      count_r <= count_r + CNT_W'(1);
      index_r <= index_r;
    end else begin
      count_r <= count_r;
      index_r <= index_r;
    end
  end

  // Free-running PWM counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_r <= {BRIGHT_W{1'b0}};
    end else begin
      pwm_r <= pwm_r + BRIGHT_W'(1);
    end
  end

  // Double buffer: a load coinciding with a commit lands in staging and stays pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      staging_r <= {BUF_W{1'b0}};
      active_r  <= {BUF_W{1'b0}};
      pending_r <= 1'b0;
    end else begin
      if (load) begin
        staging_r <= displayValues;
      end else begin
        staging_r <= staging_r;
      end
      if (wrap_s && pending_r) begin
        active_r <= staging_r;
      end else begin
        active_r <= active_r;
      end
      if (load) begin
        pending_r <= 1'b1;
      end else if (wrap_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Registered pin drivers and the frame pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anode_r      <= 7'h7F;
      cathode_r    <= {NUM_DIGITS{1'b1}};
      frame_tick_r <= 1'b0;
    end else begin
      anode_r      <= seg_decode(code_s);
      frame_tick_r <= wrap_s;
      if (enable && lit_s && !blank_s) begin
        cathode_r <= sel_s;
      end else begin
        cathode_r <= {NUM_DIGITS{1'b1}};
      end
    end
  end

`ifdef SSD_SCAN_BLINK_EN
  // Blink phase toggles after every BLINK_FRAMES frame wraps; it starts in the visible phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r   <= {BLK_W{1'b0}};
      blink_phase_r <= 1'b1;
    end else if (wrap_s) begin
      if (blink_cnt_r == BLK_LAST) begin
        blink_cnt_r   <= {BLK_W{1'b0}};
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r   <= blink_cnt_r + BLK_W'(1);
        blink_phase_r <= blink_phase_r;
      end
    end else begin
      blink_cnt_r   <= blink_cnt_r;
      blink_phase_r <= blink_phase_r;
    end
  end
`endif

  assign pending    = pending_r;
  assign frame_tick = frame_tick_r;
  assign ssdAnode   = anode_r;
  assign ssdCathode = cathode_r;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
//
// Directed bench for ssd_scan_driver with NUM_DIGITS=4 and REFRESH_DIV=4.
// The stimulus pushes the expected value for each (cycle, output) pair into
// a scoreboard queue that is kept in cycle order. A monitor samples on every
// falling edge and compares each entry that is due.
// cyc is the number of rising edges since the last reset release, so at
// cyc = c the outputs reflect the state after c edges.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

  localparam int ND = 4;
  localparam int CW = 8;

  localparam int K_CATH = 0;
  localparam int K_ANODE = 1;
  localparam int K_PEND = 2;
  localparam int K_FT = 3;

  logic             clk;
  logic             reset_n;
  logic [ND*CW-1:0] displayValues;
  logic             load;
  logic             enable;
  logic [3:0]       brightness;
  logic             pending;
  logic             frame_tick;
  logic [6:0]       ssdAnode;
  logic [ND-1:0]    ssdCathode;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc;
  int   n_vec;
  int   n_bad;
  logic [3:0] scan_pat[4];

  ssd_scan_driver #(
    .NUM_DIGITS(ND),
    .CODE_W(CW),
    .REFRESH_DIV(4),
    .BRIGHT_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .displayValues(displayValues),
    .load(load),
    .enable(enable),
    .brightness(brightness),
`ifdef SSD_SCAN_BLINK_EN
    .blink_mask(4'h0),
`endif
    .pending(pending),
    .frame_tick(frame_tick),
    .ssdAnode(ssdAnode),
    .ssdCathode(ssdCathode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Insert in cycle order so pushes from any phase keep the queue sorted.
  function automatic void expect_at(input int c, input int k, input logic [31:0] v, input string t);
    exp_t e;
    int   pos;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    e.tag = t;
    pos = sbq.size();
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    sbq.insert(pos, e);
  endfunction

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_CATH:  return {28'd0, ssdCathode};
      K_ANODE: return {25'd0, ssdAnode};
      K_PEND:  return {31'd0, pending};
      K_FT:    return {31'd0, frame_tick};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: compares every entry that is due at this sample point.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: cycle %0d not sampled (now at %0d)", e.tag, e.cyc, cyc);
      end else if (actual(e.kind) !== e.val) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got %0h, expected %0h", e.tag, e.cyc, actual(e.kind), e.val);
      end
    end
  end

  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      $display("FAIL drain: %0d expectations not reached, got %0d left, expected 0", sbq.size(), sbq.size());
      n_vec += sbq.size();
      n_bad += sbq.size();
      sbq.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    scan_pat[0] = 4'b0111;
    scan_pat[1] = 4'b1011;
    scan_pat[2] = 4'b1101;
    scan_pat[3] = 4'b1110;
    reset_n = 1'b0;
    load = 1'b0;
    enable = 1'b1;
    brightness = 4'hF;
    displayValues = 32'h0;

    // Reset state, then the basic scan at full brightness.
    expect_at(0, K_CATH, 32'hF, "rst_cathode");
    expect_at(0, K_ANODE, 32'h7F, "rst_anode");
    expect_at(0, K_PEND, 32'h0, "rst_pending");
    expect_at(0, K_FT, 32'h0, "rst_frame_tick");
    for (int c = 1; c <= 32; c++) expect_at(c, K_CATH, {28'd0, scan_pat[((c - 1) / 4) % 4]}, "scan_cathode");
    expect_at(1, K_ANODE, 32'h40, "scan_anode_zero");
    expect_at(1, K_PEND, 32'h0, "scan_pending");
    expect_at(15, K_FT, 32'h0, "ft_before");
    expect_at(16, K_FT, 32'h1, "ft_wrap1");
    expect_at(17, K_FT, 32'h0, "ft_after");
    expect_at(31, K_FT, 32'h0, "ft_before2");
    expect_at(32, K_FT, 32'h1, "ft_wrap2");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Mid-frame load is held until the frame wraps at edge 48.
    expect_at(36, K_PEND, 32'h0, "ld_pend_before");
    expect_at(37, K_PEND, 32'h1, "ld_pend_set");
    expect_at(47, K_PEND, 32'h1, "ld_pend_hold");
    expect_at(47, K_ANODE, 32'h40, "ld_old_anode");
    expect_at(48, K_PEND, 32'h0, "ld_pend_clear");
    expect_at(48, K_FT, 32'h1, "ld_ft");
    expect_at(48, K_ANODE, 32'h40, "ld_anode_pre");
    expect_at(49, K_ANODE, 32'h79, "ld_digit0_31");
    expect_at(53, K_ANODE, 32'h24, "ld_digit1_32");
    expect_at(57, K_ANODE, 32'h30, "ld_digit2_33");
    expect_at(61, K_ANODE, 32'h19, "ld_digit3_34");
    at_cyc(36); displayValues = 32'h3132_3334; load = 1'b1;
    at_cyc(37); load = 1'b0;

    // Two loads in one frame: the last one wins at the edge-80 commit.
    expect_at(66, K_PEND, 32'h1, "ll_pend1");
    expect_at(70, K_PEND, 32'h1, "ll_pend2");
    expect_at(79, K_PEND, 32'h1, "ll_pend_hold");
    expect_at(80, K_PEND, 32'h0, "ll_pend_clear");
    expect_at(80, K_ANODE, 32'h19, "ll_old_digit3");
    expect_at(81, K_ANODE, 32'h12, "ll_digit0_55");
    expect_at(85, K_ANODE, 32'h12, "ll_digit1_55");
    expect_at(93, K_ANODE, 32'h12, "ll_digit3_55");
    at_cyc(65); displayValues = 32'hAAAA_AAAA; load = 1'b1;
    at_cyc(66); load = 1'b0;
    at_cyc(69); displayValues = 32'h5555_5555; load = 1'b1;
    at_cyc(70); load = 1'b0;

    // Load in the commit cycle (edge 96): old staging shows, new one at edge 112.
    expect_at(90, K_PEND, 32'h1, "lc_pend_set");
    expect_at(96, K_PEND, 32'h1, "lc_pend_stays");
    expect_at(96, K_FT, 32'h1, "lc_ft");
    expect_at(97, K_ANODE, 32'h79, "lc_old_staging");
    expect_at(100, K_PEND, 32'h1, "lc_pend_mid");
    expect_at(111, K_ANODE, 32'h79, "lc_still_old");
    expect_at(112, K_PEND, 32'h0, "lc_pend_clear");
    expect_at(113, K_ANODE, 32'h24, "lc_new_value");
    at_cyc(89); displayValues = 32'h1111_1111; load = 1'b1;
    at_cyc(90); load = 1'b0;
    at_cyc(95); displayValues = 32'h2222_2222; load = 1'b1;
    at_cyc(96); load = 1'b0;

    // Brightness 4: lit only while pwm (= edge-1 mod 16) < 4; then brightness 0.
    for (int c = 117; c <= 132; c++) expect_at(c, K_CATH, (c >= 129) ? 32'h7 : 32'hF, "pwm4_cathode");
    for (int c = 135; c <= 150; c++) expect_at(c, K_CATH, 32'hF, "pwm0_cathode");
    at_cyc(115); brightness = 4'h4;
    at_cyc(133); brightness = 4'h0;
    at_cyc(151); brightness = 4'hF;

    // Disable mid-slot (index 2, count 2) for 10 clk; a load is held meanwhile.
    expect_at(154, K_CATH, 32'hD, "en_before");
    for (int c = 155; c <= 164; c++) expect_at(c, K_CATH, 32'hF, "en_dark");
    expect_at(157, K_PEND, 32'h1, "en_pend_set");
    expect_at(160, K_FT, 32'h0, "en_no_ft");
    expect_at(164, K_PEND, 32'h1, "en_no_commit");
    expect_at(165, K_CATH, 32'hD, "en_resume_idx2");
    expect_at(166, K_CATH, 32'hD, "en_slot_end");
    expect_at(167, K_CATH, 32'hE, "en_idx3");
    expect_at(169, K_PEND, 32'h1, "en_pend_hold");
    expect_at(169, K_FT, 32'h0, "en_ft_before");
    expect_at(170, K_FT, 32'h1, "en_ft_wrap");
    expect_at(170, K_PEND, 32'h0, "en_commit");
    expect_at(170, K_ANODE, 32'h24, "en_old_anode");
    expect_at(171, K_ANODE, 32'h10, "en_new_anode");
    expect_at(171, K_CATH, 32'h7, "en_idx0");
    at_cyc(154); enable = 1'b0;
    at_cyc(156); displayValues = 32'h9999_9999; load = 1'b1;
    at_cyc(157); load = 1'b0;
    at_cyc(164); enable = 1'b1;

    // Reset while a load is pending: staging and pending are discarded.
    expect_at(176, K_PEND, 32'h1, "rp_pend_set");
    at_cyc(175); displayValues = 32'h7777_7777; load = 1'b1;
    at_cyc(176); load = 1'b0;
    at_cyc(178);
    drain();
    #2;
    reset_n = 1'b0;
    expect_at(0, K_CATH, 32'hF, "rst2_cathode");
    expect_at(0, K_ANODE, 32'h7F, "rst2_anode");
    expect_at(0, K_PEND, 32'h0, "rst2_pending");
    expect_at(0, K_FT, 32'h0, "rst2_frame_tick");
    expect_at(1, K_CATH, 32'h7, "rst2_idx0");
    expect_at(1, K_ANODE, 32'h40, "rst2_anode_zero");
    expect_at(5, K_CATH, 32'hB, "rst2_idx1");
    expect_at(8, K_PEND, 32'h0, "rst2_pend_clear");
    expect_at(15, K_FT, 32'h0, "rst2_ft_before");
    expect_at(16, K_FT, 32'h1, "rst2_ft_wrap");
    expect_at(17, K_ANODE, 32'h40, "rst2_no_commit");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
